// File: rtl/dma_hdr_walker.sv
// dma_hdr_walker: walks the DLL/DL header lists and hands out object descriptors one at a time.
module dma_hdr_walker (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        zp_dma_start,
  input  logic        dp_dma_start,
  input  logic        dp_dma_kill,
  input  logic        last_line,
  input  logic [15:0] dpp,
  output logic        zp_dma_done,
  output logic        dp_dma_done,
  output logic        dp_dma_done_dli,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        obj_valid,
  input  logic        obj_ready,
  output logic [15:0] obj_gfx_addr,
  output logic [2:0]  obj_palette,
  output logic [4:0]  obj_width,
  output logic [7:0]  obj_hpos,
  output logic        obj_wmode,
  output logic        obj_ind
);
  typedef enum logic [2:0] {IDLE, ZP_RD, HDR_RD, OBJ_OUT, DLL_RD, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] dll_ptr, dl_ptr, walk_ptr;
  logic [3:0]  offset;
  logic        dli, dll_pending, ign, five, zp_fin, done_dli, rep_dli, pre;
  logic [2:0]  cnt;
  logic [4:0]  e0;
  logic [7:0]  e1;
  logic [7:0]  hb [5];
  logic        ack, kill, hdr_end, hdr_last, fetch_last, line_fetch;
  assign mem_rd     = (state == ZP_RD || state == HDR_RD || state == DLL_RD) && !ign;
  assign mem_addr   = !mem_rd ? 16'd0 : state == HDR_RD ? walk_ptr : dll_ptr;
  assign ack        = mem_ack && mem_rd;
  assign kill       = dp_dma_kill && (state == HDR_RD || state == OBJ_OUT);
  assign hdr_end    = state == HDR_RD && ack && cnt == 3'd1 && mem_rdata == 8'd0;
  assign hdr_last   = state == HDR_RD && ack && cnt == (five ? 3'd4 : 3'd3);
  assign fetch_last = (state == ZP_RD || state == DLL_RD) && ack && cnt == 3'd2;
  assign line_fetch = hdr_end && offset == 4'd0 && !last_line;
  assign obj_valid       = state == OBJ_OUT;
  assign zp_dma_done     = state == DONE && zp_fin;
  assign dp_dma_done     = state == DONE && !zp_fin;
  assign dp_dma_done_dli = dp_dma_done && done_dli;
  assign obj_gfx_addr = {hb[2] + {4'd0, offset}, hb[0]};
  assign obj_palette  = five ? hb[3][7:5] : hb[1][7:5];
  assign obj_width    = five ? hb[3][4:0] : hb[1][4:0];
  assign obj_hpos     = five ? hb[4] : hb[3];
  assign obj_wmode    = five && hb[1][7];
  assign obj_ind      = five && hb[1][5];
  always_ff @(posedge sysclk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (zp_dma_start) state_nx = ZP_RD;
    else if (kill) state_nx = DONE;
    else
      case (state)
        IDLE:    state_nx = dp_dma_start ? (dll_pending ? DLL_RD : HDR_RD) : IDLE;
        ZP_RD:   state_nx = fetch_last ? DONE : ZP_RD;
        DLL_RD:  state_nx = fetch_last ? (pre ? HDR_RD : DONE) : DLL_RD;
        HDR_RD:  state_nx = hdr_end ? (line_fetch ? DLL_RD : DONE) : hdr_last ? OBJ_OUT : HDR_RD;
        OBJ_OUT: state_nx = obj_ready ? HDR_RD : OBJ_OUT;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      dll_ptr <= '0; dl_ptr <= '0; walk_ptr <= '0; offset <= '0; dli <= 1'b0;
      dll_pending <= 1'b0; ign <= 1'b0; five <= 1'b0; zp_fin <= 1'b0; done_dli <= 1'b0;
      rep_dli <= 1'b0; pre <= 1'b0; cnt <= '0; e0 <= '0; e1 <= '0;
      for (int i = 0; i < 5; i++) hb[i] <= '0;
    end else begin
      if (mem_ack) ign <= 1'b0;
      // an abandoned read may still be acked later; hold off new reads until it is
      if ((zp_dma_start || kill) && mem_rd && !mem_ack) ign <= 1'b1;
      if (zp_dma_start) begin
        dll_ptr <= dpp; cnt <= '0; dll_pending <= 1'b0; zp_fin <= 1'b1; rep_dli <= 1'b0; pre <= 1'b0;
      end else if (kill) begin
        if (offset != 4'd0) offset <= offset - 4'd1;
        else if (!last_line) dll_pending <= 1'b1;
        done_dli <= rep_dli && dli;
      end else
        case (state)
          IDLE:
            if (dp_dma_start) begin
              cnt <= '0; walk_ptr <= dl_ptr; pre <= dll_pending; zp_fin <= 1'b0;
            end
          ZP_RD, DLL_RD:
            if (ack) begin
              dll_ptr <= dll_ptr + 16'd1;
              cnt <= cnt + 3'd1;
              if (cnt == 3'd0) e0 <= {mem_rdata[7], mem_rdata[3:0]};
              if (cnt == 3'd1) e1 <= mem_rdata;
              if (cnt == 3'd2) begin
                cnt <= '0; dli <= e0[4]; offset <= e0[3:0]; done_dli <= e0[4];
                dl_ptr <= {e1, mem_rdata}; walk_ptr <= {e1, mem_rdata};
                if (pre) begin dll_pending <= 1'b0; pre <= 1'b0; rep_dli <= 1'b1; end
              end
            end
          HDR_RD:
            if (ack) begin
              walk_ptr <= walk_ptr + 16'd1;
              hb[cnt] <= mem_rdata;
              cnt <= cnt + 3'd1;
              if (cnt == 3'd1) five <= mem_rdata[4:0] == 5'd0;
              if (hdr_end) begin
                cnt <= '0;
                if (offset != 4'd0) offset <= offset - 4'd1;
                done_dli <= rep_dli && dli;
              end
            end
          OBJ_OUT: if (obj_ready) cnt <= '0;
          DONE:    rep_dli <= 1'b0;
          default: ;
        endcase
    end
endmodule

// File: doc/dma_hdr_walker.md
DMA_HDR_WALKER -- requirements
Module: dma_hdr_walker

Interface
REQ-001 SHALL have ports: sysclk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: zp_dma_start  in  1  one-cycle pulse that starts the frame (DLL) fetch.
REQ-004 SHALL have ports: dp_dma_start  in  1  one-cycle pulse that starts the per-line display-list walk.
REQ-005 SHALL have ports: dp_dma_kill  in  1  abort the current line walk.
REQ-006 SHALL have ports: last_line  in  1  current line is the final visible line.
REQ-007 SHALL have ports: dpp  in  16  DLL base pointer.
REQ-008 SHALL have ports: zp_dma_done, dp_dma_done, dp_dma_done_dli  out  1  one-cycle completion pulses.
REQ-009 SHALL have ports: mem_rd  out  1, mem_addr  out  16  read request; mem_ack  in  1, mem_rdata  in  8  read data.
REQ-010 SHALL have ports: obj_valid  out  1, obj_ready  in  1, obj_gfx_addr  out  16, obj_palette  out  3, obj_width  out  5, obj_hpos  out  8, obj_wmode  out  1, obj_ind  out  1  object descriptor handshake.

Function
REQ-011 Memory handshake: mem_rd and mem_addr SHALL be held stable until the cycle mem_ack=1; mem_rdata SHALL be captured in that cycle; at most one read SHALL be outstanding; the next read SHALL not issue earlier than the cycle after the ack.
REQ-012 States SHALL be IDLE, ZP_RD, HDR_RD, OBJ_OUT, DLL_RD, DONE.
REQ-013 zp_dma_start in IDLE SHALL set dll_ptr=dpp and enter ZP_RD, which reads 3 bytes at dll_ptr, dll_ptr+1, dll_ptr+2.
REQ-014 DLL entry decoding SHALL be: byte0 = {dli, h16, h8, offset[3:0]}; dl_ptr = {byte1, byte2}; dll_ptr SHALL advance by 3, with 16-bit wrap.
REQ-015 zp_dma_done SHALL pulse in the cycle after the third ack, and the block SHALL then return to IDLE.
REQ-016 dp_dma_start in IDLE SHALL enter HDR_RD and set walk_ptr=dl_ptr.
REQ-017 HDR_RD SHALL read header bytes sequentially at walk_ptr; walk_ptr SHALL advance by one per ack, with 16-bit wrap.
REQ-018 After header byte1: if byte1==0x00, the DL has ended and the block SHALL go to line-end; if byte1[4:0]==0, the header is a 5-byte header, otherwise a 4-byte header.
REQ-019 4-byte header layout SHALL be: b0 addr low, b1 {palette[2:0], width[4:0]}, b2 addr high, b3 hpos; wmode SHALL be 0 and ind SHALL be 0.
REQ-020 5-byte header layout SHALL be: b0 addr low, b1 {wmode, 1, ind, 00000}, b2 addr high, b3 {palette, width}, b4 hpos.
REQ-021 obj_gfx_addr SHALL be {b2 + offset (8-bit, wrap), b0}.
REQ-022 OBJ_OUT SHALL assert obj_valid with stable fields until obj_ready=1; the transfer SHALL occur on the valid&ready cycle, and the block SHALL then return to HDR_RD.
REQ-023 Line-end with offset!=0: offset SHALL decrement, and dp_dma_done SHALL pulse with dp_dma_done_dli=0.
REQ-024 Line-end with offset==0 and last_line=0: the block SHALL enter DLL_RD (3-byte fetch per REQ-013/014), then pulse dp_dma_done, with dp_dma_done_dli equal to the new entry's dli bit.
REQ-025 Line-end with offset==0 and last_line=1: no DLL fetch SHALL occur, and dp_dma_done SHALL pulse with dli=0.
REQ-026 DONE SHALL last one cycle (the pulse cycle), after which the block SHALL be in IDLE.
REQ-027 dp_dma_kill in HDR_RD or OBJ_OUT: mem_rd and obj_valid SHALL drop the next cycle; any later ack for the dropped read SHALL be ignored (an ignore flag is held until the ack arrives).
REQ-028 After dp_dma_kill, line-end bookkeeping per REQ-023/025 SHALL apply, except that a required DLL fetch SHALL be deferred (dll_pending=1) and executed at the next dp_dma_start before HDR_RD, with its dli bit reported at that line's done.
REQ-029 dp_dma_kill SHALL cause dp_dma_done to pulse exactly once, 1 cycle after kill.
REQ-030 Start pulses outside IDLE SHALL be ignored, except that zp_dma_start SHALL always restart ZP_RD (frame resync) and clear dll_pending.
REQ-031 Kill while in IDLE, ZP_RD, DLL_RD or DONE SHALL be ignored.
REQ-032 Two done pulses SHALL never be asserted in the same cycle.

Reset
REQ-033 reset SHALL force state=IDLE; all outputs 0; dll_ptr, dl_ptr, walk_ptr, offset, dli, dll_pending and the ignore flag SHALL be 0.
REQ-034 Reset mid-read SHALL abandon the read, and any subsequent ack SHALL be ignored until a new read issues.

Verification
REQ-035 dpp=0x1800 holding {0x83,0x20,0x00}, zp_dma_start with 1-cycle ack latency -> reads at 0x1800-0x1802, then zp_dma_done; dl_ptr=0x2000, offset=3, dli=1.
REQ-036 DL at 0x2000 = {0x40,0x25,0xA0,0x10, 0x00,0x00}, offset=3, dp_dma_start -> one object: gfx=0xA340, palette=1, width=5, hpos=0x10; then dp_dma_done with dli=0 and offset=2.
REQ-037 5-byte header {0x00,0xC0,0x90,0x47,0x20} with obj_ready held 0 for 4 cycles -> obj_valid and fields stable throughout; wmode=1, ind=0, palette=2, width=7, hpos=0x20.
REQ-038 offset=0, next DLL entry byte0=0x80, last_line=0 -> 3 DLL reads follow the DL end; dp_dma_done and dp_dma_done_dli both 1.
REQ-039 dp_dma_kill during an outstanding header read, with ack arriving 2 cycles later -> mem_rd drops; dp_dma_done pulses once; the late ack is ignored; offset=0 sets dll_pending, and the next dp_dma_start reads the DLL first.
REQ-040 reset asserted while OBJ_OUT -> all outputs 0 immediately; after release, zp_dma_start operates normally.
